// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with a 2-entry skid buffer (main + skid) and valid/ready on both sides.
// Latency: one cycle from in_fire to out_valid/out_data when the stage is EMPTY, or BUSY with a same-cycle out_fire.
// Backpressure: in_ready drops once FULL is registered or while flush is high. out_valid holds until out_fire, flush or reset.
//
// Ports:
//   clk, reset               rising-edge clock, synchronous active-high reset
//   in_valid/in_data/in_ready    upstream handshake; in_fire = in_valid & in_ready
//   out_valid/out_data/out_ready downstream handshake; out_data = oldest entry or BUBBLE_VAL
//   flush                    discards every held entry; the stage is EMPTY on the next cycle
//   occupancy                entries held (0..2); this is the registered state encoding
//   stall_cnt                saturating count of cycles with out_valid & !out_ready
module pipe_stage_skid #(
  parameter int                DATA_W     = 32,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
  parameter int                CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  input  logic              flush,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  // The state value is the entry count, so occupancy is a direct copy of the state.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic [CNT_W-1:0]  stall_q, stall_d;

  logic in_fire;
  logic out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // State and storage registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      main_q  <= BUBBLE_VAL;
      skid_q  <= BUBBLE_VAL;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      stall_q <= stall_d;
    end
  end

  // Next state and next storage contents.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    if (flush) begin
      // A consume of main in this cycle is legal, but both entries are dropped either way.
      state_d = ST_EMPTY;
      main_d  = BUBBLE_VAL;
      skid_d  = BUBBLE_VAL;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d = ST_BUSY;
            main_d  = in_data;
          end
        end
        ST_BUSY: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            // The downstream stalled, so the new word waits behind main in skid.
            state_d = ST_FULL;
            skid_d  = in_data;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
            main_d  = BUBBLE_VAL;
          end
        end
        ST_FULL: begin
          // in_ready is low in FULL, so the only possible event is a drain into main.
          if (out_fire) begin
            state_d = ST_BUSY;
            main_d  = skid_q;
            skid_d  = BUBBLE_VAL;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = BUBBLE_VAL;
          skid_d  = BUBBLE_VAL;
        end
      endcase
    end
  end

  // The stall counter ignores flush. It stops at all-ones instead of wrapping.
  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  // Outputs. flush -> in_ready is the only combinational path through the stage.
  always_comb begin
    in_ready  = (state_q != ST_FULL) && !flush;
    out_valid = (state_q != ST_EMPTY);
    out_data  = main_q;
    occupancy = state_q;
    stall_cnt = stall_q;
  end

endmodule
